mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the datapath MEM stage and the 64-bit doubleword data RAM.
//  Converts byte-addressed LDUR/LDURSW/LDURH/LDURB and STUR/STURW/STURH/STURB requests into RAM accesses.
//  Extracts and sign/zero-extends sub-doubleword loads.
//  Performs read-modify-write for partial stores, and flags misaligned or out-of-range accesses.
//  Sits directly upstream of the data RAM and drives all of its inputs.
// PARAMETERS
//  DEPTH_DW  32  number of 64-bit RAM entries; valid byte addresses 0 .. 8*DEPTH_DW-1
//  RAM_LAT   1   cycles ram_read_en is held before ram_out is sampled (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous reset, active low
//  req_valid     in   1   request present
//  req_ready     out  1   unit idle, will accept request this cycle
//  req_write     in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 doubleword
//  req_signed    in   1   loads only: 1 sign-extend, 0 zero-extend
//  req_addr      in   64  byte address
//  req_wdata     in   64  store data, low 8/16/32/64 bits used per size
//  resp_valid    out  1   one-cycle completion pulse, loads and stores
//  resp_rdata    out  64  extended load data; 0 for stores and faults
//  resp_fault    out  1   qualified by resp_valid: misaligned or out-of-range
//  ram_address   out  64  doubleword index {3'b0, req_addr[63:3]}
//  ram_read_en   out  1   RAM read enable
//  ram_write_en  out  1   RAM write enable
//  ram_data_in   out  64  RAM write data
//  ram_out       in   64  RAM read data, valid while ram_read_en is high
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0.
//    Reset also clears all RAM enables and ram_address/ram_data_in to 0.
//  Handshake: accept on the rising edge where req_valid && req_ready.
//    At accept, latch write, size, signed, addr and wdata.
//    req_ready=1 only in IDLE, so there is never more than one outstanding request.
//  Accept checks, in order:
//    fault if addr[63:3] >= DEPTH_DW;
//    fault if addr is not a multiple of the access size (half: addr[0]; word: addr[1:0]; dword: addr[2:0]).
//  States and transitions:
//    IDLE -> FAULT on a faulting request.
//    IDLE -> RD on a load or a partial store.
//    IDLE -> WR on a doubleword store.
//    RD: ram_read_en=1 for RAM_LAT cycles; ram_out is captured on the last one. RD -> RESP (load) or RD -> WR (store).
//    WR: ram_write_en=1 for exactly one cycle, ram_data_in=merged value -> RESP.
//      Merge: captured doubleword with the bytes at offset addr[2:0] .. +size replaced by req_wdata low bytes.
//    RESP: resp_valid=1, resp_fault=0 -> IDLE.
//      Load data: bytes selected from the captured doubleword at addr[2:0], then extended per req_signed. Dword loads ignore req_signed.
//    FAULT: resp_valid=1, resp_fault=1, resp_rdata=0, no RAM enable asserted -> IDLE.
//  RAM outputs:
//    ram_read_en and ram_write_en are never high together.
//    Enables and ram_address are registered and stable for the whole state, so the RAM's level-sensitive write sees one value.
//  Latency with RAM_LAT=1, counted from the accept edge to resp_valid high:
//    load 2, partial store 3, dword store 2, fault 1.
//  resp_rdata holds its value until the next RESP or FAULT.
//  Reset mid-operation: an asserted rst_n=0 forces IDLE and drops both enables within the same cycle.
//    The in-flight request is discarded with no response.
//    A write whose WR cycle did not complete leaves the RAM unchanged.
//  Little-endian byte numbering: byte 0 = bits [7:0].
// TESTING
//  T1 dword load: RAM[3]=300; load size=11, addr=0x18.
//    -> resp_valid 2 cycles after accept, rdata=0x12C, fault=0.
//  T2 byte store then load: RAM[1]=0x64; store size=00, addr=0x0A, wdata=0xFF.
//    -> RAM[1]=0x0000_0000_00FF_0064.
//    -> signed byte load at 0x0A returns 0xFFFF_FFFF_FFFF_FFFF; unsigned returns 0xFF.
//  T3 half merge: RAM[2]=0xC8; store size=01, addr=0x16, wdata=0x1234_BEEF.
//    -> RAM[2]=0xBEEF_0000_0000_00C8; exactly one ram_write_en cycle.
//    -> signed half load at 0x16 returns 0xFFFF_FFFF_FFFF_BEEF.
//  T4 faults: word load at 0x0A, and dword load at 0x100.
//    -> each gives resp_fault=1, rdata=0, 1-cycle latency, ram_read_en/ram_write_en never high.
//  T5 reset mid-op: start a partial store to 0x10; drop rst_n during RD.
//    -> enables low immediately, RAM[2] unchanged, no resp_valid, req_ready=1 after release.
//  T6 back-to-back: req_valid held high with 3 loads at 0x00, 0x08, 0x10.
//    -> accepts spaced 3 cycles apart, responses 0, 100, 200 in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte-addressed loads/stores onto a 64-bit doubleword RAM,
// extracting/extending sub-doubleword loads, merging partial stores and flagging faults.
module mem_access_unit #(
    parameter int unsigned DEPTH_DW = 32,
    parameter int unsigned RAM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] ram_address,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [63:0] ram_data_in,
    input  logic [63:0] ram_out
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, FAULT} state_t;

    localparam int unsigned   CW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RAM_LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic          signed_q, signed_d;
    logic [1:0]    size_q, size_d;
    logic [2:0]    offset_q, offset_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          read_en_d, write_en_d, resp_valid_d, resp_fault_d;
    logic [63:0]   address_d, data_in_d, rdata_d;

    logic          misaligned, out_of_range;
    logic [5:0]    shift;
    logic [63:0]   rd_shifted, load_ext, size_mask, byte_mask, merged;

    assign req_ready = (state_q == IDLE);

    always_comb begin
        out_of_range = (req_addr[63:3] >= 61'(DEPTH_DW));
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // Extraction and merge both work on ram_out directly at the capture edge.
    always_comb begin
        shift      = {offset_q, 3'b000};
        rd_shifted = ram_out >> shift;
        case (size_q)
            2'b00: begin
                size_mask = 64'h0000_0000_0000_00FF;
                load_ext  = {{56{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            end
            2'b01: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                load_ext  = {{48{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            end
            2'b10: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                load_ext  = {{32{signed_q & rd_shifted[31]}}, rd_shifted[31:0]};
            end
            default: begin
                size_mask = '1;
                load_ext  = rd_shifted;
            end
        endcase
        byte_mask = size_mask << shift;
        merged    = (ram_out & ~byte_mask) | ((wdata_q & size_mask) << shift);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        signed_d     = signed_q;
        size_d       = size_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        address_d    = ram_address;
        data_in_d    = ram_data_in;
        rdata_d      = resp_rdata;
        read_en_d    = 1'b0;
        write_en_d   = 1'b0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    size_d   = req_size;
                    offset_d = req_addr[2:0];
                    wdata_d  = req_wdata;
                    if (out_of_range || misaligned) begin
                        state_d      = FAULT;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        address_d = {3'b000, req_addr[63:3]};
                        if (req_write && req_size == 2'b11) begin
                            state_d    = WR;
                            write_en_d = 1'b1;
                            data_in_d  = req_wdata;
                        end else begin
                            state_d   = RD;
                            read_en_d = 1'b1;
                            cnt_d     = '0;
                        end
                    end
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    if (write_q) begin
                        state_d    = WR;
                        write_en_d = 1'b1;
                        data_in_d  = merged;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        rdata_d      = load_ext;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    read_en_d = 1'b1;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                rdata_d      = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= '0;
            offset_q     <= '0;
            wdata_q      <= '0;
            ram_address  <= '0;
            ram_data_in  <= '0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            resp_valid   <= 1'b0;
            resp_fault   <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            ram_address  <= address_d;
            ram_data_in  <= data_in_d;
            ram_read_en  <= read_en_d;
            ram_write_en <= write_en_d;
            resp_valid   <= resp_valid_d;
            resp_fault   <= resp_fault_d;
            resp_rdata   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: expected responses queued at issue, compared against
// observed resp_valid pulses; a behavioural doubleword RAM sits behind the unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault, ram_read_en, ram_write_en;
    logic [63:0] resp_rdata, ram_address, ram_data_in, ram_out;

    typedef struct { logic [63:0] rdata; logic fault; int lat; } exp_t;
    typedef struct { logic [63:0] rdata; logic fault; int cyc; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   acc_q[$];
    int   cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    int   nvec = 0, nerr = 0;

    logic [63:0] mem [0:31];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = '0;
    logic [63:0] bd_data = '0;

    mem_access_unit #(.DEPTH_DW(32), .RAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .ram_address(ram_address), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
        .ram_data_in(ram_data_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    assign ram_out = (ram_address < 64'd32) ? mem[ram_address[4:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) acc_q.push_back(cyc + 1);
        if (ram_write_en && ram_address < 64'd32) mem[ram_address[4:0]] <= ram_data_in;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) obs_q.push_back('{resp_rdata, resp_fault, cyc});
            if (ram_read_en) rd_cnt <= rd_cnt + 1;
            if (ram_write_en) wr_cnt <= wr_cnt + 1;
            if (ram_read_en && ram_write_en) both_cnt <= both_cnt + 1;
        end
    end

    task automatic poke(input logic [4:0] idx, input logic [63:0] d);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] e_rdata, input logic e_fault, input int e_lat);
        bit done;
        done = 1'b0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        exp_q.push_back('{e_rdata, e_fault, e_lat});
        for (int i = 0; i < 20 && !done; i++) begin
            if (req_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL accept_timeout: addr %h not accepted in 20 cycles, req_ready=%b required 1", a, req_ready);
        end
    endtask

    task automatic wait_resp(output bit ok, output exp_t e, output obs_t o, output int lat);
        ok = 1'b0;
        lat = -1;
        o = '{64'h0, 1'b0, 0};
        e = '{64'h0, 1'b0, 0};
        for (int i = 0; i < 20 && obs_q.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (obs_q.size() > 0 && acc_q.size() > 0) begin
            o   = obs_q.pop_front();
            lat = o.cyc - acc_q.pop_front() + 1;
            ok  = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec += 4;
        if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        if ({resp_valid, resp_fault} !== 2'b00) begin nerr++; $display("FAIL reset_resp: valid/fault got %b%b required 00", resp_valid, resp_fault); end
        if (resp_rdata !== 64'h0) begin nerr++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
        if ({ram_read_en, ram_write_en} !== 2'b00 || ram_address !== 64'h0 || ram_data_in !== 64'h0) begin
            nerr++;
            $display("FAIL reset_ram: rd=%b wr=%b addr=%h din=%h required all 0", ram_read_en, ram_write_en, ram_address, ram_data_in);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        poke(5'd0, 64'd0); poke(5'd1, 64'd100); poke(5'd2, 64'd200); poke(5'd3, 64'd300);
        poke(5'd4, 64'd0); poke(5'd31, 64'h5A5A_0000_0000_A5A5);
    endtask

    task automatic test_dword_load();
        bit ok; exp_t e; obs_t o; int lat;
        send(1'b0, 2'b11, 1'b0, 64'h18, 64'h0, 64'h12C, 1'b0, 2);
        send(1'b0, 2'b11, 1'b1, 64'hF8, 64'h0, 64'h5A5A_0000_0000_A5A5, 1'b0, 2);
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_resp(ok, e, o, lat);
            nvec += 4;
            if (!ok) begin nerr++; $display("FAIL t1_resp[%0d]: no response in 20 cycles, required one", k); end
            if (o.rdata !== e.rdata) begin nerr++; $display("FAIL t1_rdata[%0d]: got %h required %h", k, o.rdata, e.rdata); end
            if (o.fault !== e.fault) begin nerr++; $display("FAIL t1_fault[%0d]: got %b required %b", k, o.fault, e.fault); end
            if (lat != e.lat) begin nerr++; $display("FAIL t1_latency[%0d]: got %0d required %0d", k, lat, e.lat); end
        end
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (resp_rdata !== 64'h5A5A_0000_0000_A5A5) begin nerr++; $display("FAIL t1_rdata_hold: got %h required 5a5a00000000a5a5", resp_rdata); end
    endtask

    task automatic test_byte_store();
        bit ok; exp_t e; obs_t o; int lat;
        send(1'b1, 2'b00, 1'b0, 64'h0A, 64'hFF, 64'h0, 1'b0, 3);
        send(1'b0, 2'b00, 1'b1, 64'h0A, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
        send(1'b0, 2'b00, 1'b0, 64'h0A, 64'h0, 64'hFF, 1'b0, 2);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_resp(ok, e, o, lat);
            nvec += 4;
            if (!ok) begin nerr++; $display("FAIL t2_resp[%0d]: no response in 20 cycles, required one", k); end
            if (o.rdata !== e.rdata) begin nerr++; $display("FAIL t2_rdata[%0d]: got %h required %h", k, o.rdata, e.rdata); end
            if (o.fault !== e.fault) begin nerr++; $display("FAIL t2_fault[%0d]: got %b required %b", k, o.fault, e.fault); end
            if (lat != e.lat) begin nerr++; $display("FAIL t2_latency[%0d]: got %0d required %0d", k, lat, e.lat); end
        end
        nvec++;
        if (mem[1] !== 64'h0000_0000_00FF_0064) begin nerr++; $display("FAIL t2_ram1: got %h required 0000000000ff0064", mem[1]); end
    endtask

    task automatic test_half_merge();
        bit ok; exp_t e; obs_t o; int lat; int w0;
        w0 = wr_cnt;
        send(1'b1, 2'b01, 1'b0, 64'h16, 64'h1234_BEEF, 64'h0, 1'b0, 3);
        req_valid = 1'b0;
        wait_resp(ok, e, o, lat);
        nvec += 4;
        if (!ok) begin nerr++; $display("FAIL t3_resp: no response in 20 cycles, required one"); end
        if (o.rdata !== e.rdata || o.fault !== e.fault) begin nerr++; $display("FAIL t3_store_resp: rdata %h fault %b required %h %b", o.rdata, o.fault, e.rdata, e.fault); end
        if (lat != e.lat) begin nerr++; $display("FAIL t3_latency: got %0d required %0d", lat, e.lat); end
        if (wr_cnt - w0 != 1) begin nerr++; $display("FAIL t3_write_cycles: got %0d required 1", wr_cnt - w0); end
        nvec++;
        if (mem[2] !== 64'hBEEF_0000_0000_00C8) begin nerr++; $display("FAIL t3_ram2: got %h required beef0000000000c8", mem[2]); end
        send(1'b0, 2'b01, 1'b1, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 2);
        req_valid = 1'b0;
        wait_resp(ok, e, o, lat);
        nvec += 2;
        if (!ok) begin nerr++; $display("FAIL t3_load_resp: no response in 20 cycles, required one"); end
        if (o.rdata !== e.rdata) begin nerr++; $display("FAIL t3_load_rdata: got %h required %h", o.rdata, e.rdata); end
    endtask

    task automatic test_word_dword();
        bit ok; exp_t e; obs_t o; int lat;
        send(1'b1, 2'b11, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 2);
        send(1'b1, 2'b10, 1'b0, 64'h24, 64'hFFFF_FFFF_8000_0001, 64'h0, 1'b0, 3);
        send(1'b0, 2'b10, 1'b1, 64'h24, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b0, 2);
        send(1'b0, 2'b10, 1'b0, 64'h20, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0, 2);
        send(1'b0, 2'b01, 1'b0, 64'h22, 64'h0, 64'h0000_0000_0000_89AB, 1'b0, 2);
        send(1'b0, 2'b01, 1'b1, 64'h22, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 1'b0, 2);
        send(1'b0, 2'b11, 1'b1, 64'h20, 64'h0, 64'h8000_0001_89AB_CDEF, 1'b0, 2);
        send(1'b0, 2'b00, 1'b1, 64'h27, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2);
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_resp(ok, e, o, lat);
            nvec += 4;
            if (!ok) begin nerr++; $display("FAIL wd_resp[%0d]: no response in 20 cycles, required one", k); end
            if (o.rdata !== e.rdata) begin nerr++; $display("FAIL wd_rdata[%0d]: got %h required %h", k, o.rdata, e.rdata); end
            if (o.fault !== e.fault) begin nerr++; $display("FAIL wd_fault[%0d]: got %b required %b", k, o.fault, e.fault); end
            if (lat != e.lat) begin nerr++; $display("FAIL wd_latency[%0d]: got %0d required %0d", k, lat, e.lat); end
        end
        nvec++;
        if (mem[4] !== 64'h8000_0001_89AB_CDEF) begin nerr++; $display("FAIL wd_ram4: got %h required 8000000189abcdef", mem[4]); end
    endtask

    task automatic test_faults();
        bit ok; exp_t e; obs_t o; int lat; int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        send(1'b0, 2'b10, 1'b0, 64'h0A, 64'h0, 64'h0, 1'b1, 1);
        send(1'b0, 2'b11, 1'b0, 64'h100, 64'h0, 64'h0, 1'b1, 1);
        send(1'b1, 2'b01, 1'b0, 64'h03, 64'hFFFF, 64'h0, 1'b1, 1);
        send(1'b0, 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 1'b1, 1);
        send(1'b1, 2'b11, 1'b0, 64'h101, 64'h1, 64'h0, 1'b1, 1);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_resp(ok, e, o, lat);
            nvec += 4;
            if (!ok) begin nerr++; $display("FAIL t4_resp[%0d]: no response in 20 cycles, required one", k); end
            if (o.rdata !== e.rdata) begin nerr++; $display("FAIL t4_rdata[%0d]: got %h required %h", k, o.rdata, e.rdata); end
            if (o.fault !== e.fault) begin nerr++; $display("FAIL t4_fault[%0d]: got %b required %b", k, o.fault, e.fault); end
            if (lat != e.lat) begin nerr++; $display("FAIL t4_latency[%0d]: got %0d required %0d", k, lat, e.lat); end
        end
        nvec += 2;
        if (rd_cnt != r0 || wr_cnt != w0) begin nerr++; $display("FAIL t4_enables: read/write cycles got %0d/%0d required 0/0", rd_cnt - r0, wr_cnt - w0); end
        if (mem[0] !== 64'h0) begin nerr++; $display("FAIL t4_ram0: got %h required 0", mem[0]); end
    endtask

    task automatic test_reset_midop();
        poke(5'd2, 64'd200);
        send(1'b1, 2'b00, 1'b0, 64'h10, 64'hAA, 64'h0, 1'b0, 3);
        req_valid = 1'b0;
        nvec++;
        if (ram_read_en !== 1'b1) begin nerr++; $display("FAIL t5_in_rd: ram_read_en got %b required 1", ram_read_en); end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({ram_read_en, ram_write_en} !== 2'b00) begin nerr++; $display("FAIL t5_enables: rd/wr got %b%b required 00", ram_read_en, ram_write_en); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        nvec += 3;
        if (obs_q.size() != 0) begin nerr++; $display("FAIL t5_no_resp: responses got %0d required 0", obs_q.size()); end
        if (mem[2] !== 64'd200) begin nerr++; $display("FAIL t5_ram2: got %h required 00000000000000c8", mem[2]); end
        if (req_ready !== 1'b1) begin nerr++; $display("FAIL t5_ready: got %b required 1", req_ready); end
        exp_q.delete();
        obs_q.delete();
        acc_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok; exp_t e; obs_t o; int lat;
        poke(5'd0, 64'd0); poke(5'd1, 64'd100); poke(5'd2, 64'd200);
        send(1'b0, 2'b11, 1'b0, 64'h00, 64'h0, 64'd0, 1'b0, 2);
        send(1'b0, 2'b11, 1'b0, 64'h08, 64'h0, 64'd100, 1'b0, 2);
        send(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'd200, 1'b0, 2);
        req_valid = 1'b0;
        nvec++;
        if (acc_q.size() != 3) begin
            nerr++; $display("FAIL t6_accepts: got %0d required 3", acc_q.size());
        end else begin
            nvec++;
            if (acc_q[1] - acc_q[0] != 3 || acc_q[2] - acc_q[1] != 3) begin
                nerr++;
                $display("FAIL t6_spacing: got %0d,%0d required 3,3", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            wait_resp(ok, e, o, lat);
            nvec += 4;
            if (!ok) begin nerr++; $display("FAIL t6_resp[%0d]: no response in 20 cycles, required one", k); end
            if (o.rdata !== e.rdata) begin nerr++; $display("FAIL t6_rdata[%0d]: got %h required %h", k, o.rdata, e.rdata); end
            if (o.fault !== e.fault) begin nerr++; $display("FAIL t6_fault[%0d]: got %b required %b", k, o.fault, e.fault); end
            if (lat != e.lat) begin nerr++; $display("FAIL t6_latency[%0d]: got %0d required %0d", k, lat, e.lat); end
        end
        nvec++;
        if (both_cnt != 0) begin nerr++; $display("FAIL rw_exclusive: cycles with both enables got %0d required 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_dword_load();
        test_byte_store();
        test_half_merge();
        test_word_dword();
        test_faults();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
